demux_rr_dispatcher: RTL and testbench

DEMUX_RR_DISPATCHER -- requirements
Module: demux_rr_dispatcher

---
 rtl/demux_disp_pkg.sv | 40 ++++
 rtl/demux_route8.sv | 20 ++
 rtl/demux_rr_dispatcher.sv | 106 ++++++++++
 tb/tb_demux_rr_dispatcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_disp_pkg.sv
// ----------------------------------------------------------------------------
// demux_disp_pkg
// Shared definitions for the round-robin / fixed-destination dispatcher:
//   NUM_CH  - number of destination channels (fixed at 8)
//   SEL_W   - width of a channel index (3)
//   state_e - dispatcher FSM states (IDLE, ARB, SEND)
//   rr_pick - round-robin search helper: first ready channel at or after ptr
// ----------------------------------------------------------------------------
package demux_disp_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    // Returns the first index k in ptr, ptr+1, ... ptr+NUM_CH-1 (mod NUM_CH)
    // whose ready bit is set; falls back to ptr when nothing is ready.
    // The loop runs from the farthest offset down to offset 0 so that the
    // nearest ready channel is the last (and therefore winning) assignment.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [SEL_W-1:0]  ptr,
        input logic [NUM_CH-1:0] ready
    );
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        pick = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (ready[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/demux_route8.sv
// ----------------------------------------------------------------------------
// demux_route8
// Combinational 1:8 router of a single valid bit.
//   valid_i  - valid bit to route
//   sel_i    - destination channel index
//   valid_o  - one-hot (or all-zero) per-channel valid; only bit sel_i may be 1
// ----------------------------------------------------------------------------
module demux_route8
    import demux_disp_pkg::*;
(
    input  logic              valid_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [NUM_CH-1:0] valid_o
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_route
        assign valid_o[gi] = valid_i && (sel_i == SEL_W'(gi));
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// ----------------------------------------------------------------------------
// demux_rr_dispatcher
// Accepts one word at a time from upstream, chooses a destination channel
// (round-robin over ready channels, or a fixed index), and presents the word
// on a shared data bus with a one-hot per-channel valid until taken.
//   clk, rst     - clock, asynchronous active-high reset
//   in_valid     - upstream word available
//   in_data      - upstream payload
//   in_ready     - word accepted this cycle (IDLE only)
//   mode         - 0 = round-robin destination, 1 = fixed destination
//   fixed_sel    - destination used when mode = 1
//   out_ready    - per-channel downstream ready
//   out_valid    - per-channel valid, at most one bit high
//   out_data     - shared payload bus
//   cur_sel      - destination of the word being held
//   xfer_count   - completed output transfers (wraps at 16 bits)
// ----------------------------------------------------------------------------
module demux_rr_dispatcher
    import demux_disp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  fixed_sel,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [NUM_CH-1:0] out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  cur_sel,
    output logic [15:0]       xfer_count
);

    state_e            state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  cur_sel_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] out_data_q;
    logic [15:0]       xfer_count_q;
    // Mode latched at arbitration so the pointer update on completion belongs
    // to the word in flight, not to whatever mode is applied later.
    logic              mode_q;

    logic [SEL_W-1:0]  sel_d;
    logic              send_done;

    assign sel_d     = mode ? fixed_sel : rr_pick(ptr_q, out_ready);
    // Only the selected channel's ready matters; the others are ignored.
    assign send_done = (state_q == ST_SEND) && out_ready[cur_sel_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cur_sel_q    <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            xfer_count_q <= '0;
            mode_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        hold_q  <= in_data;
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    cur_sel_q  <= sel_d;
                    mode_q     <= mode;
                    // out_data changes only when a new word enters SEND, so
                    // it keeps the previous word while IDLE/ARB.
                    out_data_q <= hold_q;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (send_done) begin
                        xfer_count_q <= xfer_count_q + 16'd1;
                        if (!mode_q) begin
                            ptr_q <= cur_sel_q + SEL_W'(1);
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    demux_route8 u_route (
        .valid_i (state_q == ST_SEND),
        .sel_i   (cur_sel_q),
        .valid_o (out_valid)
    );

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_data   = out_data_q;
    assign cur_sel    = cur_sel_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_demux_rr_dispatcher
// Directed scenarios for demux_rr_dispatcher; one line per transaction.
// ----------------------------------------------------------------------------
module tb_demux_rr_dispatcher;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mode;
    logic [2:0]  fixed_sel;
    logic [7:0]  out_ready;
    logic [7:0]  out_valid;
    logic [7:0]  out_data;
    logic [2:0]  cur_sel;
    logic [15:0] xfer_count;

    int n_cmp = 0;
    int n_err = 0;

    demux_rr_dispatcher #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mode       (mode),
        .fixed_sel  (fixed_sel),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .cur_sel    (cur_sel),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offers one word from IDLE; returns at the falling edge where the DUT
    // sits in ARB (word accepted on the intervening rising edge).
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        mode = 1'b0; fixed_sel = 3'd0; out_ready = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 8'h00) begin n_err++; $display("FAIL rst_out_valid: got %h want 00", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_cmp++; if (cur_sel !== 3'd0) begin n_err++; $display("FAIL rst_cur_sel: got %0d want 0", cur_sel); end
        n_cmp++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", xfer_count); end
        // Release reset and offer a word immediately: first edge must take it.
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL first_edge_accept: in_ready got %b want 0 (ARB)", in_ready); end
        // Reset while in ARB discards the word.
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arb_rst_ready: got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 8'h00) begin n_err++; $display("FAIL arb_rst_valid: got %h want 00", out_valid); end
        n_cmp++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL arb_rst_count: got %0d want 0", xfer_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arb_rst_idle: in_ready got %b want 1", in_ready); end
        $display("reset: checks done, word 3C discarded in ARB");
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_sel;
        mode = 1'b0; out_ready = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_sel = 3'(i % 8);
            push(8'h10 + 8'(i));
            @(negedge clk);
            n_cmp++; if (cur_sel !== exp_sel) begin n_err++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, cur_sel, exp_sel); end
            n_cmp++; if (out_valid !== (8'h01 << exp_sel)) begin n_err++; $display("FAIL rr_valid[%0d]: got %h want %h", i, out_valid, 8'h01 << exp_sel); end
            n_cmp++; if (out_data !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(i)); end
            @(negedge clk);
            n_cmp++; if (out_valid !== 8'h00 || in_ready !== 1'b1) begin n_err++; $display("FAIL rr_idle[%0d]: valid %h ready %b want 00/1", i, out_valid, in_ready); end
            n_cmp++; if (out_data !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL rr_data_hold[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(i)); end
            $display("rr: word %h -> ch %0d count %0d", out_data, exp_sel, xfer_count);
        end
        n_cmp++; if (xfer_count !== 16'd9) begin n_err++; $display("FAIL rr_count: got %0d want 9", xfer_count); end
    endtask

    task automatic test_skip();
        // ptr is 1 after the round-robin run; one transfer moves it to 2.
        mode = 1'b0; out_ready = 8'hFF;
        push(8'h20);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd1) begin n_err++; $display("FAIL skip_prep: got %0d want 1", cur_sel); end
        @(negedge clk);
        out_ready = 8'b0010_0000;
        push(8'h55);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd5) begin n_err++; $display("FAIL skip_sel: got %0d want 5", cur_sel); end
        n_cmp++; if (out_valid !== 8'h20) begin n_err++; $display("FAIL skip_valid: got %h want 20", out_valid); end
        @(negedge clk);
        $display("skip: word 55 -> ch 5 count %0d", xfer_count);
        out_ready = 8'hFF;
        push(8'h56);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd6) begin n_err++; $display("FAIL skip_ptr: next sel got %0d want 6", cur_sel); end
        @(negedge clk);
        n_cmp++; if (xfer_count !== 16'd12) begin n_err++; $display("FAIL skip_count: got %0d want 12", xfer_count); end
    endtask

    task automatic test_no_ready();
        // ptr is 7; only channel 3 ready -> ptr becomes 4.
        mode = 1'b0; out_ready = 8'b0000_1000;
        push(8'h30);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd3) begin n_err++; $display("FAIL nr_prep: got %0d want 3", cur_sel); end
        @(negedge clk);
        out_ready = 8'h00;
        push(8'h31);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (cur_sel !== 3'd4 || out_valid !== 8'h10) begin n_err++; $display("FAIL nr_hold[%0d]: sel %0d valid %h want 4/10", c, cur_sel, out_valid); end
            // Every channel except 4 ready: must be ignored.
            out_ready = 8'hEF;
        end
        out_ready = 8'h10;
        @(negedge clk);
        n_cmp++; if (out_valid !== 8'h00 || xfer_count !== 16'd14) begin n_err++; $display("FAIL nr_done: valid %h count %0d want 00/14", out_valid, xfer_count); end
        $display("no_ready: word 31 -> ch 4 count %0d", xfer_count);
    endtask

    task automatic test_fixed();
        // ptr is 5 here; fixed mode must not move it.
        mode = 1'b1; fixed_sel = 3'd3; out_ready = 8'h00;
        push(8'hA5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 8'h08 || out_data !== 8'hA5 || cur_sel !== 3'd3) begin
                n_err++; $display("FAIL fix_hold[%0d]: valid %h data %h sel %0d want 08/A5/3", c, out_valid, out_data, cur_sel);
            end
            if (c == 1) begin mode = 1'b0; fixed_sel = 3'd6; end
            if (c == 2) out_ready = 8'hF7;
            if (c == 4) out_ready = 8'h08;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 8'h00 || xfer_count !== 16'd15) begin n_err++; $display("FAIL fix_done: valid %h count %0d want 00/15", out_valid, xfer_count); end
        $display("fixed: word A5 -> ch 3 count %0d", xfer_count);
        mode = 1'b0; out_ready = 8'hFF;
        push(8'hA6);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd5) begin n_err++; $display("FAIL fix_ptr_kept: got %0d want 5", cur_sel); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        // ptr is 6, count 16. Preload the counter just below wrap.
        mode = 1'b0; out_ready = 8'hFF;
        @(negedge clk);
        force dut.xfer_count_q = 16'hFFFE;
        #1;
        release dut.xfer_count_q;
        push(8'hE0);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd6) begin n_err++; $display("FAIL wrap_sel6: got %0d want 6", cur_sel); end
        @(negedge clk);
        n_cmp++; if (xfer_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h want FFFF", xfer_count); end
        push(8'hE1);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd7) begin n_err++; $display("FAIL wrap_sel7: got %0d want 7", cur_sel); end
        @(negedge clk);
        n_cmp++; if (xfer_count !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h want 0000", xfer_count); end
        push(8'hE2);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd0) begin n_err++; $display("FAIL wrap_ptr: got %0d want 0", cur_sel); end
        @(negedge clk);
        n_cmp++; if (xfer_count !== 16'h0001) begin n_err++; $display("FAIL wrap_after: got %h want 0001", xfer_count); end
        $display("wrap: count wrapped to 0, ptr wrapped 7->0, count %0d", xfer_count);
    endtask

    task automatic test_reset_mid_send();
        mode = 1'b0; out_ready = 8'h00;
        push(8'h77);
        @(negedge clk);
        n_cmp++; if (out_valid !== 8'h02) begin n_err++; $display("FAIL mid_send_pre: got %h want 02", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 8'h00) begin n_err++; $display("FAIL mid_rst_valid: got %h want 00", out_valid); end
        n_cmp++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", xfer_count); end
        n_cmp++; if (out_data !== 8'h00 || cur_sel !== 3'd0) begin n_err++; $display("FAIL mid_rst_regs: data %h sel %0d want 00/0", out_data, cur_sel); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle: in_ready got %b want 1", in_ready); end
        out_ready = 8'hFF;
        push(8'h78);
        @(negedge clk);
        n_cmp++; if (cur_sel !== 3'd0) begin n_err++; $display("FAIL mid_rst_ptr: got %0d want 0", cur_sel); end
        @(negedge clk);
        n_cmp++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL mid_rst_after: got %0d want 1", xfer_count); end
        $display("reset_mid_send: word 77 discarded, word 78 -> ch 0 count %0d", xfer_count);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip();
        test_no_ready();
        test_fixed();
        test_wrap();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
